// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM state and transaction owner.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/arb_watchdog.sv
// Per-transaction wait counter; flags expiry after TIMEOUT_CYCLES-1 counted waits.
// With TIMEOUT_CYCLES = 0 the counter is pinned at zero and never expires.
module arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Saturates at CNT_MAX so the count can never wrap back into range.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && (count == CNT_LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the IFU (read-only) and
// the LSU (read/write); one transaction in flight, with a response watchdog.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                clock,
  input  logic                reset,

  input  logic                ifu_reqValid,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_respValid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_err,

  input  logic                lsu_reqValid,
  input  logic                lsu_wen,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_respValid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_err,

  output logic                mem_reqValid,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_respValid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_abort,

  output arb_state_t          dbg_state
);

  // Handshake: a requester raises reqValid with a stable payload and holds both
  // until its one-cycle respValid pulse, then drops reqValid by the next cycle.
  // Toward memory, mem_reqValid is a single-cycle pulse answered by exactly one
  // mem_respValid pulse (possibly in the same cycle) or cancelled by mem_abort.

  arb_state_t          state_q, state_d;
  arb_owner_t          owner_q, last_owner_q, grant_owner;
  logic                grant;
  logic                capture_resp, capture_timeout;
  logic                wd_clear, wd_enable, wd_expired;

  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic [DATA_W-1:0]   ifu_rdata_q, lsu_rdata_q;
  logic                ifu_err_q, lsu_err_q;
  logic                abort_q;
  logic                mem_active;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    grant           = 1'b0;
    grant_owner     = OWN_IFU;
    capture_resp    = 1'b0;
    capture_timeout = 1'b0;
    wd_clear        = 1'b0;
    wd_enable       = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (ifu_reqValid && lsu_reqValid) begin
          grant       = 1'b1;
          grant_owner = (last_owner_q == OWN_LSU) ? OWN_IFU : OWN_LSU;
        end else if (ifu_reqValid) begin
          grant       = 1'b1;
          grant_owner = OWN_IFU;
        end else if (lsu_reqValid) begin
          grant       = 1'b1;
          grant_owner = OWN_LSU;
        end
        if (grant) begin
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        wd_clear = 1'b1;
        if (mem_respValid) begin
          capture_resp = 1'b1;
          state_d      = ARB_RESP;
        end else begin
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (mem_respValid) begin
          capture_resp = 1'b1;
          state_d      = ARB_RESP;
        end else if (wd_expired) begin
          capture_timeout = 1'b1;
          state_d         = ARB_RESP;
        end else begin
          wd_enable = 1'b1;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q      <= OWN_IFU;
      last_owner_q <= OWN_LSU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      ifu_rdata_q  <= '0;
      lsu_rdata_q  <= '0;
      ifu_err_q    <= 1'b0;
      lsu_err_q    <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      abort_q <= capture_timeout;
      if (grant) begin
        owner_q      <= grant_owner;
        last_owner_q <= grant_owner;
        // IFU is fetch-only, so its write side is forced quiet at grant time.
        if (grant_owner == OWN_IFU) begin
          addr_q  <= ifu_addr;
          wen_q   <= 1'b0;
          wdata_q <= '0;
          wmask_q <= '0;
        end else begin
          addr_q  <= lsu_addr;
          wen_q   <= lsu_wen;
          wdata_q <= lsu_wdata;
          wmask_q <= lsu_wmask;
        end
      end
      if (capture_resp || capture_timeout) begin
        if (owner_q == OWN_IFU) begin
          ifu_rdata_q <= capture_resp ? mem_rdata : '0;
          ifu_err_q   <= capture_timeout;
        end else begin
          lsu_rdata_q <= capture_resp ? mem_rdata : '0;
          lsu_err_q   <= capture_timeout;
        end
      end
    end
  end

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  assign mem_active    = (state_q == ARB_ISSUE) || (state_q == ARB_WAIT);
  assign mem_reqValid  = (state_q == ARB_ISSUE);
  assign mem_wen       = mem_active ? wen_q   : 1'b0;
  assign mem_addr      = mem_active ? addr_q  : '0;
  assign mem_wdata     = mem_active ? wdata_q : '0;
  assign mem_wmask     = mem_active ? wmask_q : '0;
  assign mem_abort     = abort_q;

  assign ifu_respValid = (state_q == ARB_RESP) && (owner_q == OWN_IFU);
  assign lsu_respValid = (state_q == ARB_RESP) && (owner_q == OWN_LSU);
  assign ifu_rdata     = ifu_respValid ? ifu_rdata_q : '0;
  assign ifu_err       = ifu_respValid && ifu_err_q;
  assign lsu_rdata     = lsu_respValid ? lsu_rdata_q : '0;
  assign lsu_err       = lsu_respValid && lsu_err_q;

  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with an 8-cycle watchdog.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ifu_reqValid = 1'b0;
  logic [AW-1:0] ifu_addr = '0;
  logic          ifu_respValid;
  logic [DW-1:0] ifu_rdata;
  logic          ifu_err;
  logic          lsu_reqValid = 1'b0;
  logic          lsu_wen = 1'b0;
  logic [AW-1:0] lsu_addr = '0;
  logic [DW-1:0] lsu_wdata = '0;
  logic [MW-1:0] lsu_wmask = '0;
  logic          lsu_respValid;
  logic [DW-1:0] lsu_rdata;
  logic          lsu_err;
  logic          mem_reqValid;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic          mem_respValid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_abort;
  arb_state_t    dbg_state;

  logic [138:0]  all_out;
  int checks = 0;
  int errors = 0;
  int ifu_resp_cnt = 0;
  int lsu_resp_cnt = 0;
  int overlap_cnt = 0;
  logic outstanding = 1'b0;

  always #5 clock = ~clock;

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
    .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_reqValid(lsu_reqValid), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_reqValid(mem_reqValid), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_respValid(mem_respValid), .mem_rdata(mem_rdata), .mem_abort(mem_abort),
    .dbg_state(dbg_state)
  );

  assign all_out = {mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wmask, mem_abort,
                    ifu_respValid, ifu_rdata, ifu_err, lsu_respValid, lsu_rdata, lsu_err};

  // Response counters and single-outstanding monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (reset) begin
      outstanding = 1'b0;
    end else begin
      if (mem_reqValid && outstanding) overlap_cnt++;
      if (mem_reqValid) outstanding = 1'b1;
      if (ifu_respValid) begin ifu_resp_cnt++; outstanding = 1'b0; end
      if (lsu_respValid) begin lsu_resp_cnt++; outstanding = 1'b0; end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish, required finish before 500us");
    $fatal(1, "bench timeout");
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic mem_reply(input int delay, input logic [DW-1:0] data);
    step(delay);
    mem_respValid = 1'b1;
    mem_rdata     = data;
    step();
    mem_respValid = 1'b0;
    mem_rdata     = '0;
  endtask

  task automatic wait_issue(output int n);
    n = 0;
    while (mem_reqValid !== 1'b1 && n < 20) begin step(); n++; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    checks++; if (dbg_state !== ARB_IDLE) begin errors++; $display("FAIL reset_state got %0d expected %0d", dbg_state, ARB_IDLE); end
    checks++; if (all_out !== '0) begin errors++; $display("FAIL reset_outputs got %h expected 0", all_out); end
    reset = 1'b0;
    step(3);
    checks++; if (all_out !== '0) begin errors++; $display("FAIL idle_quiet got %h expected 0", all_out); end
  endtask

  task automatic test_simultaneous();
    int n;
    logic [AW-1:0] exp_addr;
    logic [1:0]    exp_resp;
    ifu_reqValid = 1'b1; ifu_addr = 32'h0000_0100;
    lsu_reqValid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      wait_issue(n);
      checks++; if (n >= 20) begin errors++; $display("FAIL rr_issue_%0d got no mem_reqValid expected one within 20 cycles", i); end
      exp_addr = (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
      exp_resp = (i % 2 == 0) ? 2'b10 : 2'b01;
      checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL rr_grant_%0d got addr %h expected %h", i, mem_addr, exp_addr); end
      mem_reply(1, 32'hA000_0000 + DW'(i));
      checks++; if ({ifu_respValid, lsu_respValid} !== exp_resp) begin errors++; $display("FAIL rr_resp_%0d got %b expected %b", i, {ifu_respValid, lsu_respValid}, exp_resp); end
    end
    ifu_reqValid = 1'b0; lsu_reqValid = 1'b0;
    step();
    checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL rr_single_outstanding got %0d overlaps expected 0", overlap_cnt); end
  endtask

  task automatic test_ifu_read();
    int ifu0, lsu0;
    ifu0 = ifu_resp_cnt; lsu0 = lsu_resp_cnt;
    ifu_reqValid = 1'b1; ifu_addr = 32'h8000_0000;
    step();
    checks++; if ({mem_reqValid, mem_wen, mem_addr, mem_wmask} !== {1'b1, 1'b0, 32'h8000_0000, 4'h0}) begin
      errors++; $display("FAIL ifu_issue got %h expected %h", {mem_reqValid, mem_wen, mem_addr, mem_wmask}, {1'b1, 1'b0, 32'h8000_0000, 4'h0}); end
    step();
    checks++; if ({mem_reqValid, mem_addr} !== {1'b0, 32'h8000_0000}) begin
      errors++; $display("FAIL ifu_wait_hold got %h expected %h", {mem_reqValid, mem_addr}, {1'b0, 32'h8000_0000}); end
    step();
    mem_respValid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_respValid = 1'b0; mem_rdata = '0; ifu_reqValid = 1'b0;
    checks++; if ({ifu_respValid, ifu_rdata, ifu_err, lsu_respValid} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
      errors++; $display("FAIL ifu_resp got %h expected %h", {ifu_respValid, ifu_rdata, ifu_err, lsu_respValid}, {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0}); end
    step();
    checks++; if ({ifu_respValid, mem_addr} !== '0) begin errors++; $display("FAIL ifu_resp_pulse got %h expected 0", {ifu_respValid, mem_addr}); end
    step();
    checks++; if ((ifu_resp_cnt - ifu0) !== 1 || (lsu_resp_cnt - lsu0) !== 0) begin
      errors++; $display("FAIL ifu_resp_count got ifu %0d lsu %0d expected ifu 1 lsu 0", ifu_resp_cnt - ifu0, lsu_resp_cnt - lsu0); end
  endtask

  task automatic test_lsu_store();
    lsu_reqValid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h0000_1000;
    lsu_wdata = 32'h1234_5678; lsu_wmask = 4'b0011;
    step();
    checks++; if ({mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wmask} !== {1'b1, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'b0011}) begin
      errors++; $display("FAIL lsu_issue got %h expected %h", {mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wmask}, {1'b1, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'b0011}); end
    lsu_addr = 32'hDEAD_0000; lsu_wdata = 32'hFFFF_FFFF; lsu_wmask = 4'hF; lsu_wen = 1'b0;
    step();
    checks++; if ({mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wmask} !== {1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'b0011}) begin
      errors++; $display("FAIL lsu_payload_latched got %h expected %h", {mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wmask}, {1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'b0011}); end
    mem_respValid = 1'b1; mem_rdata = 32'h0000_0000;
    step();
    mem_respValid = 1'b0; lsu_reqValid = 1'b0;
    checks++; if ({lsu_respValid, lsu_err, ifu_respValid} !== 3'b100) begin
      errors++; $display("FAIL lsu_resp got %b expected 100", {lsu_respValid, lsu_err, ifu_respValid}); end
    step();
    checks++; if ({lsu_respValid, dbg_state} !== {1'b0, ARB_IDLE}) begin
      errors++; $display("FAIL lsu_resp_pulse got %b expected %b", {lsu_respValid, dbg_state}, {1'b0, ARB_IDLE}); end
    lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
  endtask

  task automatic test_timeout();
    int n;
    ifu_reqValid = 1'b1; ifu_addr = 32'h0000_4000;
    step();
    n = 0;
    while (mem_abort !== 1'b1 && n < 20) begin step(); n++; end
    checks++; if (n !== TO + 1) begin errors++; $display("FAIL timeout_latency got %0d cycles after issue expected %0d", n, TO + 1); end
    checks++; if ({ifu_respValid, ifu_err, ifu_rdata, lsu_respValid} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL timeout_resp got %h expected %h", {ifu_respValid, ifu_err, ifu_rdata, lsu_respValid}, {1'b1, 1'b1, 32'h0, 1'b0}); end
    ifu_reqValid = 1'b0;
    step();
    checks++; if ({mem_abort, ifu_respValid} !== 2'b00) begin errors++; $display("FAIL timeout_abort_pulse got %b expected 00", {mem_abort, ifu_respValid}); end
    lsu_reqValid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h0000_5000;
    wait_issue(n);
    checks++; if ({mem_addr, mem_wen} !== {32'h0000_5000, 1'b0}) begin
      errors++; $display("FAIL post_timeout_issue got %h expected %h", {mem_addr, mem_wen}, {32'h0000_5000, 1'b0}); end
    mem_reply(1, 32'h55AA_33CC);
    lsu_reqValid = 1'b0;
    checks++; if ({lsu_respValid, lsu_rdata, lsu_err} !== {1'b1, 32'h55AA_33CC, 1'b0}) begin
      errors++; $display("FAIL post_timeout_resp got %h expected %h", {lsu_respValid, lsu_rdata, lsu_err}, {1'b1, 32'h55AA_33CC, 1'b0}); end
    step();
  endtask

  task automatic test_zero_latency();
    int ifu0, lsu0;
    ifu0 = ifu_resp_cnt; lsu0 = lsu_resp_cnt;
    ifu_reqValid = 1'b1; ifu_addr = 32'h0000_2000;
    step();
    checks++; if (mem_reqValid !== 1'b1) begin errors++; $display("FAIL zl_issue got %b expected 1", mem_reqValid); end
    mem_respValid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    step();
    checks++; if ({dbg_state, ifu_respValid, ifu_rdata, ifu_err} !== {ARB_RESP, 1'b1, 32'h0BAD_F00D, 1'b0}) begin
      errors++; $display("FAIL zl_resp got %h expected %h", {dbg_state, ifu_respValid, ifu_rdata, ifu_err}, {ARB_RESP, 1'b1, 32'h0BAD_F00D, 1'b0}); end
    ifu_reqValid = 1'b0; mem_rdata = 32'h1111_1111;
    step();
    step();
    mem_respValid = 1'b0; mem_rdata = '0;
    checks++; if ({dbg_state, ifu_respValid, lsu_respValid, mem_reqValid} !== {ARB_IDLE, 3'b000}) begin
      errors++; $display("FAIL stray_resp_state got %b expected %b", {dbg_state, ifu_respValid, lsu_respValid, mem_reqValid}, {ARB_IDLE, 3'b000}); end
    step();
    checks++; if ((ifu_resp_cnt - ifu0) !== 1 || (lsu_resp_cnt - lsu0) !== 0) begin
      errors++; $display("FAIL stray_resp_count got ifu %0d lsu %0d expected ifu 1 lsu 0", ifu_resp_cnt - ifu0, lsu_resp_cnt - lsu0); end
  endtask

  task automatic test_reset_mid();
    int n;
    ifu_reqValid = 1'b1; ifu_addr = 32'h0000_6000;
    step(2);
    checks++; if (dbg_state !== ARB_WAIT) begin errors++; $display("FAIL rst_mid_pre got %0d expected %0d", dbg_state, ARB_WAIT); end
    reset = 1'b1; ifu_reqValid = 1'b0;
    step();
    checks++; if ({dbg_state, all_out} !== {ARB_IDLE, 139'h0}) begin
      errors++; $display("FAIL rst_mid_outputs got %h expected %h", {dbg_state, all_out}, {ARB_IDLE, 139'h0}); end
    reset = 1'b0;
    step();
    ifu_reqValid = 1'b1; ifu_addr = 32'h0000_3000;
    lsu_reqValid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h0000_3100;
    wait_issue(n);
    checks++; if (mem_addr !== 32'h0000_3000) begin errors++; $display("FAIL rst_mid_tie got addr %h expected %h", mem_addr, 32'h0000_3000); end
    mem_reply(1, 32'h600D_CAFE);
    ifu_reqValid = 1'b0; lsu_reqValid = 1'b0;
    checks++; if ({ifu_respValid, ifu_rdata, lsu_respValid} !== {1'b1, 32'h600D_CAFE, 1'b0}) begin
      errors++; $display("FAIL rst_mid_resp got %h expected %h", {ifu_respValid, ifu_rdata, lsu_respValid}, {1'b1, 32'h600D_CAFE, 1'b0}); end
    step(2);
    checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL final_single_outstanding got %0d overlaps expected 0", overlap_cnt); end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_ifu_read();
    test_lsu_store();
    test_timeout();
    test_zero_latency();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Sits between the IFU/LSU handshake interfaces and the SoC memory bus.
- Registers the winning request, sequences one transaction at a time, and routes the response back to its owner.
- Includes a per-transaction watchdog that aborts a transaction and returns an error if memory never answers.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT_CYCLES, 256, cycles to wait for mem_respValid before abort; 0 disables the watchdog

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
ifu_reqValid  input  1  IFU read request, held with ifu_addr until ifu_respValid
ifu_addr  input  ADDR_W  IFU fetch address
ifu_respValid  output  1  one-cycle pulse: IFU response ready
ifu_rdata  output  DATA_W  IFU read data, valid with ifu_respValid
ifu_err  output  1  IFU transaction timed out, valid with ifu_respValid
lsu_reqValid  input  1  LSU request, held with payload until lsu_respValid
lsu_wen  input  1  1 = store, 0 = load
lsu_addr  input  ADDR_W  LSU address
lsu_wdata  input  DATA_W  store data
lsu_wmask  input  DATA_W/8  store byte mask
lsu_respValid  output  1  one-cycle pulse: LSU response ready
lsu_rdata  output  DATA_W  load data, valid with lsu_respValid
lsu_err  output  1  LSU transaction timed out, valid with lsu_respValid
mem_reqValid  output  1  one-cycle request pulse to memory
mem_wen  output  1  write enable to memory
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_wmask  output  DATA_W/8  memory byte mask
mem_respValid  input  1  one-cycle memory response pulse
mem_rdata  input  DATA_W  memory read data
mem_abort  output  1  one-cycle pulse: memory must drop the outstanding transaction

Behaviour:
- **Reset state.** State is ARB_IDLE. All outputs are 0. The wait counter is 0. last_owner = OWN_LSU, so the IFU wins the first tie.
- **States:** ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP.
- **ARB_IDLE**
  - Sample the two reqValid signals.
  - If only one is asserted, that requester wins.
  - If both are asserted, the requester not equal to last_owner wins (round-robin).
  - On a grant: latch owner, addr, wen, wdata and wmask into registers; update last_owner; go to ARB_ISSUE.
  - For an IFU grant, latched wen = 0 and wmask = 0.
  - With no request, stay in ARB_IDLE.
- **ARB_ISSUE**
  - mem_reqValid = 1 for exactly this cycle.
  - mem_addr, mem_wen, mem_wdata and mem_wmask come from the latched registers, are stable from ARB_ISSUE through ARB_WAIT, and are 0 otherwise.
  - Clear the wait counter; go to ARB_WAIT.
  - If mem_respValid arrives in ARB_ISSUE, handle it exactly as in ARB_WAIT (zero-latency memory is legal).
- **ARB_WAIT**
  - On mem_respValid: latch mem_rdata into the owner's rdata register, set err = 0, go to ARB_RESP.
  - Otherwise increment the wait counter.
  - When TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES - 1 without a response:
    - assert mem_abort for one cycle (the following cycle);
    - latch rdata = 0 and err = 1;
    - go to ARB_RESP.
  - The wait counter width is $clog2(TIMEOUT_CYCLES+1) and it never wraps.
- **ARB_RESP**
  - The owner's respValid = 1 for exactly this one cycle; rdata and err are driven from registers.
  - The other requester's respValid stays 0.
  - Go to ARB_IDLE.
  - The requester must deassert reqValid by the cycle after its respValid, so ARB_IDLE never re-grants a serviced request.
- **Latency.** Request sampled in ARB_IDLE at cycle 0 → mem_reqValid at cycle 1 → mem_respValid at cycle N → owner respValid at cycle N+1. Minimum round trip is 3 cycles (grant, issue with immediate response, respond).
- **Non-owner waiting.** A requester arriving while the arbiter is busy waits; its reqValid and payload must stay stable and it is evaluated in the next ARB_IDLE.
- **Stray mem_respValid** in ARB_IDLE or ARB_RESP is ignored. The bench checks that no respValid is generated.
- **Payload changes mid-transaction.** Inputs changing after the grant have no effect; only the latched values are used.
- **Reset mid-transaction.** The arbiter returns to ARB_IDLE next cycle with all outputs 0 and no mem_abort. Memory is reset by the same signal.
- **Fairness.** Under continuous requests from both units, grants strictly alternate IFU, LSU, IFU, ...

Decomposition:
- Package mem_arb_pkg holds:
  - the arb_state_t enum (ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP);
  - the arb_owner_t enum (OWN_IFU, OWN_LSU).
- One sub-module, arb_watchdog: the wait counter with clear/enable inputs and an expired output; it is tied off when TIMEOUT_CYCLES = 0.
- Round-robin selection stays inline.

Test Plan:
- **IFU-only read.** ifu_reqValid with ifu_addr=0x8000_0000; memory answers 2 cycles after mem_reqValid with 0xDEAD_BEEF → mem_wen=0, mem_wmask=0, ifu_rdata=0xDEAD_BEEF, ifu_err=0, ifu_respValid one cycle, lsu_respValid never asserted.
- **LSU store.** lsu_wen=1, addr 0x1000, wdata 0x1234_5678, wmask 0b0011 → mem outputs match exactly during ARB_ISSUE; lsu_respValid one cycle after mem_respValid.
- **Simultaneous requests from reset.** Both requesters held for 4 transactions → grant order IFU, LSU, IFU, LSU; never two outstanding mem_reqValid.
- **Timeout.** TIMEOUT_CYCLES=8, memory silent → mem_abort pulse after 8 wait cycles; owner respValid with err=1, rdata=0; next request is serviced normally.
- **Zero-latency memory.** mem_respValid in the same cycle as mem_reqValid → owner respValid the next cycle, round trip 3 cycles.
- **Reset mid-transaction.** Reset asserted in ARB_WAIT → next cycle all outputs 0, state ARB_IDLE; a subsequent IFU request completes, with the IFU winning a tie.
